// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, state encoding and the register-match helper for the
// pipeline hazard controller.
package hazard_ctrl_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // EX result-source encoding; RES_SRC_MEM marks a load
  localparam logic [1:0] RES_SRC_ALU = 2'b00;
  localparam logic [1:0] RES_SRC_MEM = 2'b01;
  localparam logic [1:0] RES_SRC_PC4 = 2'b10;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_REDIRECT = 1'b1
  } hz_state_e;

  // A write to x0 is discarded by the regfile, so it never creates a hazard
  // and is never a forwarding source.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic we);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding source select for one EX operand: MEM result wins over WB result.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_addr,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_rd_we,
  input  logic [4:0] wb_rd_addr,
  input  logic       wb_rd_we,
  output logic [1:0] sel
);

  // Pick the youngest in-flight producer of rs_addr.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = FWD_NONE;
    if (reg_match(mem_rd_addr, rs_addr, mem_rd_we)) begin
      sel = FWD_MEM;
    end else if (reg_match(wb_rd_addr, rs_addr, wb_rd_we)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stalls, bubbles, redirect
// flush sequencing, EX operand forwarding and stall/flush event counters.
// Optional feature macro: HAZARD_FWD_EN (forwarding with load-use stall only);
// without it the pipeline stalls on every RAW dependency until the producer
// has written back.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       ex_rs1_addr,
  input  logic [4:0]       ex_rs2_addr,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_we,
  input  logic [1:0]       ex_res_src,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_rd_we,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_rd_we,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // rcnt only has to hold REDIRECT_CYCLES-1.
  localparam int RCNT_W = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REDIRECT_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              redirect_flush;
  logic              data_hazard;

  // ID reads a register that a given stage is about to write.
  function automatic logic id_reads(input logic [4:0] rd, input logic we);
    return reg_match(rd, id_rs1_addr, we) || reg_match(rd, id_rs2_addr, we);
  endfunction

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign data_hazard = (ex_res_src == RES_SRC_MEM) && id_reads(ex_rd_addr, ex_rd_we);

  hazard_fwd_sel u_fwd_a (
    .rs_addr     (ex_rs1_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_we   (mem_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_we    (wb_rd_we),
    .sel         (fwd_a_raw)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_addr     (ex_rs2_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_we   (mem_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_we    (wb_rd_we),
    .sel         (fwd_b_raw)
  );

  // Selects read as FWD_NONE while the core is held in reset.
  assign fwd_a_sel = rst_n ? fwd_a_raw : FWD_NONE;
  assign fwd_b_sel = rst_n ? fwd_b_raw : FWD_NONE;
`else
  // No bypass network: hold ID until the producer has left WB, since the
  // regfile only takes the write at the clock edge.
  assign data_hazard = id_reads(ex_rd_addr, ex_rd_we) ||
                       id_reads(mem_rd_addr, mem_rd_we) ||
                       id_reads(wb_rd_addr, wb_rd_we);

  assign fwd_a_sel = FWD_NONE;
  assign fwd_b_sel = FWD_NONE;

  // EX operand addresses and result source only matter for forwarding.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = &{1'b0, ex_rs1_addr, ex_rs2_addr, ex_res_src};
`endif

  // Redirect FSM state and remaining-flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      rcnt_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Redirect sequencing: the redirect cycle itself plus REDIRECT_CYCLES-1 more.
  always_comb begin
    state_d        = state_q;
    rcnt_d         = rcnt_q;
    redirect_flush = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        if (ex_redirect) begin
          redirect_flush = 1'b1;
          if (REDIRECT_CYCLES > 1) begin
            state_d = HZ_REDIRECT;
            rcnt_d  = RCNT_RELOAD;
          end
        end
      end
      HZ_REDIRECT: begin
        redirect_flush = 1'b1;
        if (ex_redirect) begin
          rcnt_d = RCNT_RELOAD;
        end else if (rcnt_q == RCNT_W'(1)) begin
          state_d = HZ_RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q - RCNT_W'(1);
        end
      end
      default: begin
        state_d = HZ_RUN;
        rcnt_d  = '0;
      end
    endcase
  end

  // Pipeline control: redirect flush beats a data-hazard stall; all quiet in reset.
  always_comb begin
    stall_if = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    if (!rst_n) begin
      stall_if = 1'b0;
    end else if (redirect_flush) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (data_hazard) begin
      stall_if = 1'b1;
      flush_id = 1'b1;
    end
  end

  assign stall_id = stall_if;

  // Performance counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Expected control values are queued as
// each step is driven and popped when the step's outputs are sampled.
// Expectations follow HAZARD_FWD_EN when the bench is built with it defined.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        flush_if;
    logic        flush_id;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] scnt;
    logic [31:0] fcnt;
    logic        flush1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr;
  logic [4:0]  ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic        ex_rd_we, mem_rd_we, wb_rd_we, ex_redirect;
  logic [1:0]  ex_res_src;

  logic        stall_if, stall_id, flush_if, flush_id;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

  logic        stall_if1, stall_id1, flush_if1, flush_id1;
  logic [1:0]  fwd_a_sel1, fwd_b_sel1;
  logic [31:0] stall_cnt1, flush_cnt1;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_scnt = '0;
  logic [31:0] m_fcnt = '0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REDIRECT_CYCLES(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_res_src(ex_res_src),
    .ex_redirect(ex_redirect),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we),
    .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
    .stall_if(stall_if), .stall_id(stall_id), .flush_if(flush_if), .flush_id(flush_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Single-cycle redirect variant on the same stimulus; only its flush_if is checked.
  hazard_ctrl #(.REDIRECT_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_res_src(ex_res_src),
    .ex_redirect(ex_redirect),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we),
    .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
    .stall_if(stall_if1), .stall_id(stall_id1), .flush_if(flush_if1), .flush_id(flush_id1),
    .fwd_a_sel(fwd_a_sel1), .fwd_b_sel(fwd_b_sel1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  function automatic logic [1:0] fw(input logic [1:0] v);
    return FWD_ON ? v : FWD_NONE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] irs1, input logic [4:0] irs2,
                        input logic [4:0] ers1, input logic [4:0] ers2,
                        input logic [4:0] erd, input logic ewe, input logic [1:0] esrc,
                        input logic redir, input logic [4:0] mrd, input logic mwe,
                        input logic [4:0] wrd, input logic wwe);
    id_rs1_addr = irs1; id_rs2_addr = irs2;
    ex_rs1_addr = ers1; ex_rs2_addr = ers2;
    ex_rd_addr  = erd;  ex_rd_we    = ewe;  ex_res_src = esrc;
    ex_redirect = redir;
    mem_rd_addr = mrd;  mem_rd_we   = mwe;
    wb_rd_addr  = wrd;  wb_rd_we    = wwe;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 1'b0, RES_SRC_ALU, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Queue the expectation for the cycle just driven, then compare mid-cycle.
  task automatic step(input string tag, input logic s, input logic fi, input logic fd,
                      input logic [1:0] fa, input logic [1:0] fb, input logic f1);
    exp_t e;
    exp_t got;
    e.stall = s; e.flush_if = fi; e.flush_id = fd;
    e.fwd_a = fa; e.fwd_b = fb; e.flush1 = f1;
    e.scnt = m_scnt; e.fcnt = m_fcnt;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({tag, " stall_if"},  32'(stall_if),  32'(got.stall));
      check({tag, " stall_id"},  32'(stall_id),  32'(got.stall));
      check({tag, " flush_if"},  32'(flush_if),  32'(got.flush_if));
      check({tag, " flush_id"},  32'(flush_id),  32'(got.flush_id));
      check({tag, " fwd_a"},     32'(fwd_a_sel), 32'(got.fwd_a));
      check({tag, " fwd_b"},     32'(fwd_b_sel), 32'(got.fwd_b));
      check({tag, " stall_cnt"}, stall_cnt,      got.scnt);
      check({tag, " flush_cnt"}, flush_cnt,      got.fcnt);
      check({tag, " rc1 flush"}, 32'(flush_if1), 32'(got.flush1));
    end
    if (s)  m_scnt = m_scnt + 32'd1;
    if (fi) m_fcnt = m_fcnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with every hazard source active: outputs must stay quiet.
    rst_n = 1'b0;
    set_in(5, 0, 0, 3, 5, 1'b1, RES_SRC_MEM, 1'b1, 3, 1'b1, 0, 1'b0);
    step("in_reset", 0, 0, 0, FWD_NONE, FWD_NONE, 0);
    rst_n = 1'b1;
    idle();
    step("post_reset", 0, 0, 0, FWD_NONE, FWD_NONE, 0);

    // Load x5 in EX, ID reads x5: one stall+bubble, then EX takes x5 from WB.
    set_in(5, 0, 0, 0, 5, 1'b1, RES_SRC_MEM, 1'b0, 0, 1'b0, 0, 1'b0);
    step("load_use", 1, 0, 1, FWD_NONE, FWD_NONE, 0);
    set_in(0, 0, 5, 0, 0, 1'b0, RES_SRC_ALU, 1'b0, 0, 1'b0, 5, 1'b1);
    step("load_use_next", 0, 0, 0, fw(FWD_WB), FWD_NONE, 0);

    // Forwarding patterns, MEM priority and x0 exclusion.
    set_in(0, 0, 0, 3, 0, 1'b0, RES_SRC_ALU, 1'b0, 3, 1'b1, 3, 1'b1);
    step("fwd_mem_prio", 0, 0, 0, FWD_NONE, fw(FWD_MEM), 0);
    set_in(0, 0, 3, 3, 0, 1'b0, RES_SRC_ALU, 1'b0, 3, 1'b0, 3, 1'b1);
    step("fwd_mem_no_we", 0, 0, 0, fw(FWD_WB), fw(FWD_WB), 0);
    set_in(0, 0, 2, 7, 0, 1'b0, RES_SRC_ALU, 1'b0, 2, 1'b1, 7, 1'b1);
    step("fwd_split", 0, 0, 0, fw(FWD_MEM), fw(FWD_WB), 0);
    set_in(0, 0, 0, 0, 0, 1'b1, RES_SRC_MEM, 1'b0, 0, 1'b1, 0, 1'b1);
    step("x0_all", 0, 0, 0, FWD_NONE, FWD_NONE, 0);

    // ADD x7 travels EX -> MEM -> WB while ID reads x7.
    set_in(0, 7, 0, 0, 7, 1'b1, RES_SRC_ALU, 1'b0, 0, 1'b0, 0, 1'b0);
    step("raw_ex", !FWD_ON, 0, !FWD_ON, FWD_NONE, FWD_NONE, 0);
    set_in(0, 7, 0, 0, 0, 1'b0, RES_SRC_ALU, 1'b0, 7, 1'b1, 0, 1'b0);
    step("raw_mem", !FWD_ON, 0, !FWD_ON, FWD_NONE, FWD_NONE, 0);
    set_in(0, 7, 0, 0, 0, 1'b0, RES_SRC_ALU, 1'b0, 0, 1'b0, 7, 1'b1);
    step("raw_wb", !FWD_ON, 0, !FWD_ON, FWD_NONE, FWD_NONE, 0);
    set_in(0, 7, 0, 0, 0, 1'b0, RES_SRC_ALU, 1'b0, 0, 1'b0, 0, 1'b0);
    step("raw_release", 0, 0, 0, FWD_NONE, FWD_NONE, 0);

    // Redirect pulse: three flush cycles; a load-use during REDIRECT is ignored.
    idle(); ex_redirect = 1'b1;
    step("redir_c1", 0, 1, 1, FWD_NONE, FWD_NONE, 1);
    set_in(5, 0, 0, 0, 5, 1'b1, RES_SRC_MEM, 1'b0, 0, 1'b0, 0, 1'b0);
    step("redir_c2", 0, 1, 1, FWD_NONE, FWD_NONE, 0);
    idle();
    step("redir_c3", 0, 1, 1, FWD_NONE, FWD_NONE, 0);
    step("redir_done", 0, 0, 0, FWD_NONE, FWD_NONE, 0);

    // Second redirect inside REDIRECT reloads the count.
    ex_redirect = 1'b1;
    step("reload_c1", 0, 1, 1, FWD_NONE, FWD_NONE, 1);
    step("reload_c2", 0, 1, 1, FWD_NONE, FWD_NONE, 1);
    ex_redirect = 1'b0;
    step("reload_c3", 0, 1, 1, FWD_NONE, FWD_NONE, 0);
    step("reload_c4", 0, 1, 1, FWD_NONE, FWD_NONE, 0);
    step("reload_done", 0, 0, 0, FWD_NONE, FWD_NONE, 0);

    // Redirect together with a load-use match: flush only, no stall.
    set_in(5, 0, 0, 0, 5, 1'b1, RES_SRC_MEM, 1'b1, 0, 1'b0, 0, 1'b0);
    step("redir_vs_stall", 0, 1, 1, FWD_NONE, FWD_NONE, 1);
    idle();
    step("rvs_c2", 0, 1, 1, FWD_NONE, FWD_NONE, 0);
    step("rvs_c3", 0, 1, 1, FWD_NONE, FWD_NONE, 0);
    step("rvs_done", 0, 0, 0, FWD_NONE, FWD_NONE, 0);

    // Reset asserted in the second REDIRECT cycle.
    ex_redirect = 1'b1;
    step("rst_redir_c1", 0, 1, 1, FWD_NONE, FWD_NONE, 1);
    idle();
    rst_n  = 1'b0;
    m_scnt = '0;
    m_fcnt = '0;
    step("rst_mid_redir", 0, 0, 0, FWD_NONE, FWD_NONE, 0);
    rst_n = 1'b1;
    step("rst_run", 0, 0, 0, FWD_NONE, FWD_NONE, 0);
    set_in(5, 0, 0, 0, 5, 1'b1, RES_SRC_MEM, 1'b0, 0, 1'b0, 0, 1'b0);
    step("rst_load_use", 1, 0, 1, FWD_NONE, FWD_NONE, 0);
    idle();
    step("rst_cnt", 0, 0, 0, FWD_NONE, FWD_NONE, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
